// File: rtl/fifo_ram_ctrl.sv
// Control stage for the streaming FIFO: drives the external dual-port RAM and hides its read
// latency behind a small credit-limited output buffer. Optional flags: `FIFO_ALMOST_FLAGS_EN.
module fifo_ram_ctrl #(
   parameter int WIDTH         = 32,
   parameter int ADDR_WIDTH    = 4,
   parameter int DEPTH         = 16,
   parameter int RD_LATENCY    = 1,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [ADDR_WIDTH+1:0] usedw,
   output logic                  ram_clken,
   output logic [ADDR_WIDTH-1:0] ram_address_a,
   output logic                  ram_wren_a,
   output logic [WIDTH-1:0]      ram_data_a,
   output logic [ADDR_WIDTH-1:0] ram_address_b,
   input  logic [WIDTH-1:0]      ram_q_b
`ifdef FIFO_ALMOST_FLAGS_EN
   ,
   output logic                  almost_full,
   output logic                  almost_empty
`endif
);

   localparam int CW  = ADDR_WIDTH + 2;
   localparam int OB  = RD_LATENCY + 2;
   localparam int OBW = $clog2(OB);

   localparam logic [CW-1:0]         LP_ONE     = CW'(1);
   localparam logic [CW-1:0]         LP_DEPTH   = CW'(DEPTH);
   localparam logic [CW-1:0]         LP_CREDITS = CW'(OB);
   localparam logic [ADDR_WIDTH-1:0] LP_PTR_ONE = ADDR_WIDTH'(1);
   localparam logic [OBW-1:0]        LP_OB_ONE  = OBW'(1);
   localparam logic [OBW-1:0]        LP_OB_LAST = OBW'(OB - 1);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CW-1:0]         r_ram_count;
   logic [RD_LATENCY-1:0] r_vpipe;
   logic [WIDTH-1:0]      r_obuf [OB];
   logic [OBW-1:0]        r_ob_wr;
   logic [OBW-1:0]        r_ob_rd;
   logic [CW-1:0]         r_ob_count;
   logic [CW-1:0]         r_usedw;

   logic                  w_push;
   logic                  w_issue;
   logic                  w_load;
   logic                  w_pop;
   logic [CW-1:0]         w_inflight;
   logic [CW-1:0]         w_inflight_nxt;
   logic [CW-1:0]         w_ram_count_nxt;
   logic [CW-1:0]         w_ob_count_nxt;
   logic [CW-1:0]         w_usedw_nxt;
   logic [RD_LATENCY-1:0] w_vpipe_nxt;

   function automatic logic [CW-1:0] f_popcount(input logic [RD_LATENCY-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         if (v[i]) n = n + LP_ONE;
      end
      return n;
   endfunction

   function automatic logic [OBW-1:0] f_ob_inc(input logic [OBW-1:0] p);
      return (p == LP_OB_LAST) ? '0 : p + LP_OB_ONE;
   endfunction

   // Issue decisions look only at registered counts, so a read can never hit this cycle's write.
   assign in_ready   = ~reset & (r_ram_count != LP_DEPTH);
   assign w_push     = in_valid & in_ready;
   assign w_inflight = f_popcount(r_vpipe);
   assign w_issue    = (r_ram_count != '0) && ((w_inflight + r_ob_count) < LP_CREDITS);
   assign w_load     = r_vpipe[RD_LATENCY-1];
   assign out_valid  = (r_ob_count != '0);
   assign w_pop      = out_valid & out_ready;

   always_comb begin
      w_ram_count_nxt = r_ram_count;
      if (w_push && !w_issue) w_ram_count_nxt = r_ram_count + LP_ONE;
      else if (!w_push && w_issue) w_ram_count_nxt = r_ram_count - LP_ONE;

      w_ob_count_nxt = r_ob_count;
      if (w_load && !w_pop) w_ob_count_nxt = r_ob_count + LP_ONE;
      else if (!w_load && w_pop) w_ob_count_nxt = r_ob_count - LP_ONE;

      w_vpipe_nxt    = r_vpipe << 1;
      w_vpipe_nxt[0] = w_issue;
   end

   assign w_inflight_nxt = f_popcount(w_vpipe_nxt);
   assign w_usedw_nxt    = w_ram_count_nxt + w_inflight_nxt + w_ob_count_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_ram_count <= '0;
         r_vpipe     <= '0;
         r_ob_wr     <= '0;
         r_ob_rd     <= '0;
         r_ob_count  <= '0;
         r_usedw     <= '0;
      end else begin
         if (w_push)  r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
         if (w_issue) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
         r_ram_count <= w_ram_count_nxt;
         r_vpipe     <= w_vpipe_nxt;
         if (w_load) begin
            r_obuf[r_ob_wr] <= ram_q_b;
            r_ob_wr         <= f_ob_inc(r_ob_wr);
         end
         if (w_pop) r_ob_rd <= f_ob_inc(r_ob_rd);
         r_ob_count <= w_ob_count_nxt;
         r_usedw    <= w_usedw_nxt;
      end
   end

`ifdef FIFO_ALMOST_FLAGS_EN
   logic r_almost_full;
   logic r_almost_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
      end else begin
         r_almost_full  <= (w_usedw_nxt >= CW'(AFULL_THRESH));
         r_almost_empty <= (w_usedw_nxt <= CW'(AEMPTY_THRESH));
      end
   end

   assign almost_full  = r_almost_full;
   assign almost_empty = r_almost_empty;
`endif

   assign usedw         = r_usedw;
   assign out_data      = r_obuf[r_ob_rd];
   assign ram_clken     = 1'b1;
   assign ram_address_a = r_wr_ptr;
   assign ram_wren_a    = w_push;
   assign ram_data_a    = in_data;
   assign ram_address_b = r_rd_ptr;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl: a RD_LATENCY=1 instance and a RD_LATENCY=3 instance, each with a
// behavioural RAM, checked against queue-based scoreboards.
module tb_fifo_ram_ctrl;
   localparam int W     = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Instance A: RD_LATENCY = 1
   logic          in_valid, in_ready, out_valid, out_ready, ram_clken, ram_wren_a;
   logic [W-1:0]  in_data, out_data, ram_data_a, ram_q_b;
   logic [AW+1:0] usedw;
   logic [AW-1:0] ram_address_a, ram_address_b;

   // Instance B: RD_LATENCY = 3
   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ram_clken, b_ram_wren_a;
   logic [W-1:0]  b_in_data, b_out_data, b_ram_data_a, b_ram_q_b;
   logic [AW+1:0] b_usedw;
   logic [AW-1:0] b_ram_address_a, b_ram_address_b;

   fifo_ram_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(1),
                   .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .usedw(usedw), .ram_clken(ram_clken),
      .ram_address_a(ram_address_a), .ram_wren_a(ram_wren_a), .ram_data_a(ram_data_a),
      .ram_address_b(ram_address_b), .ram_q_b(ram_q_b)
   );

   fifo_ram_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(3),
                   .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_dut_l3 (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .usedw(b_usedw), .ram_clken(b_ram_clken),
      .ram_address_a(b_ram_address_a), .ram_wren_a(b_ram_wren_a), .ram_data_a(b_ram_data_a),
      .ram_address_b(b_ram_address_b), .ram_q_b(b_ram_q_b)
   );

   // Behavioural RAMs with 1- and 3-cycle port B latency
   logic [W-1:0] mem_a [DEPTH];
   logic [W-1:0] rq_a;
   always @(posedge clk) begin
      if (ram_wren_a) mem_a[ram_address_a] <= ram_data_a;
      rq_a <= mem_a[ram_address_b];
   end
   assign ram_q_b = rq_a;

   logic [W-1:0] mem_b [DEPTH];
   logic [W-1:0] rq_b [3];
   always @(posedge clk) begin
      if (b_ram_wren_a) mem_b[b_ram_address_a] <= b_ram_data_a;
      rq_b[0] <= mem_b[b_ram_address_b];
      rq_b[1] <= rq_b[0];
      rq_b[2] <= rq_b[1];
   end
   assign b_ram_q_b = rq_b[2];

   // Scoreboards: expected words queued on accepted pushes, popped on accepted pops
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  exp_b[$];
   int            m_cnt;
   logic [AW-1:0] m_wr;

   always @(negedge clk) begin
      logic [W-1:0] e;
      if (reset) begin
         exp_q.delete();
         exp_b.delete();
         m_cnt = 0;
         m_wr  = '0;
      end else begin
         checks++;
         if (usedw !== (AW+2)'(m_cnt)) begin
            failures++;
            $display("FAIL usedw got=%0d exp=%0d", usedw, m_cnt);
         end
         checks++;
         if (ram_address_a !== m_wr) begin
            failures++;
            $display("FAIL wr_addr got=%0d exp=%0d", ram_address_a, m_wr);
         end
         checks++;
         if (ram_wren_a !== (in_valid & in_ready) || ram_data_a !== in_data) begin
            failures++;
            $display("FAIL ram_port_a wren=%0b data=%0h exp_wren=%0b exp_data=%0h",
                     ram_wren_a, ram_data_a, in_valid & in_ready, in_data);
         end
         checks++;
         if (out_valid === 1'b1 && exp_q.size() == 0) begin
            failures++;
            $display("FAIL spurious_valid got=1 exp=0");
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  failures++;
                  $display("FAIL out_data got=%0h exp=%0h", out_data, e);
               end
            end
            m_cnt--;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            m_cnt++;
            m_wr++;
         end
         if (b_out_valid && b_out_ready) begin
            checks++;
            if (exp_b.size() == 0) begin
               failures++;
               $display("FAIL b_pop_empty got=1 exp=0");
            end else begin
               e = exp_b.pop_front();
               if (b_out_data !== e) begin
                  failures++;
                  $display("FAIL b_out_data got=%0h exp=%0h", b_out_data, e);
               end
            end
         end
         if (b_in_valid && b_in_ready) exp_b.push_back(b_in_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_data = 32'h0000_1234; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || ram_wren_a !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags rdy=%0b vld=%0b wren=%0b exp=0", in_ready, out_valid, ram_wren_a);
      end
      checks++;
      if (usedw !== '0 || b_usedw !== '0 || b_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_usedw got=%0d/%0d exp=0", usedw, b_usedw);
      end
      checks++;
      if (ram_clken !== 1'b1 || b_ram_clken !== 1'b1) begin
         failures++;
         $display("FAIL clken got=%0b exp=1", ram_clken);
      end
      @(posedge clk);
      #1;
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_ready got=%0b exp=1", in_ready);
      end
      step();
   endtask

   task automatic test_single_word();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_0001;
      step();
      in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== (c == 3)) begin
            failures++;
            $display("FAIL single_valid c=%0d got=%0b exp=%0b", c, out_valid, c == 3);
         end
         if (c == 3) begin
            checks++;
            if (out_data !== 32'hA5A5_0001) begin
               failures++;
               $display("FAIL single_data got=%0h exp=a5a50001", out_data);
            end
         end
         checks++;
         if (usedw !== ((c < 4) ? 6'd1 : 6'd0)) begin
            failures++;
            $display("FAIL single_usedw c=%0d got=%0d", c, usedw);
         end
         step();
      end
   endtask

   task automatic test_fill();
      int acc = 0;
      out_ready = 1'b0;
      for (int i = 0; i <= 20; i++) begin
         in_valid = 1'b1; in_data = 32'h1000_0000 + i;
         @(negedge clk);
         if (in_ready) acc++;
         if (i >= 19) begin
            checks++;
            if (in_ready !== 1'b0) begin
               failures++;
               $display("FAIL fill_ready i=%0d got=%0b exp=0", i, in_ready);
            end
         end
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();
      @(negedge clk);
      checks++;
      if (acc != 19 || usedw !== 6'd19 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL fill_capacity acc=%0d usedw=%0d rdy=%0b exp=19/19/0", acc, usedw, in_ready);
      end
      step();
      out_ready = 1'b1;
      for (int t = 0; t < 40 && exp_q.size() != 0; t++) step();
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || usedw !== '0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL fill_drain left=%0d usedw=%0d exp=0", exp_q.size(), usedw);
      end
      step();
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int c = 0; c < 106; c++) begin
         in_valid = (c < 100); in_data = 32'h5000_0000 + c;
         @(negedge clk);
         if (c < 100) begin
            checks++;
            if (in_ready !== 1'b1) begin
               failures++;
               $display("FAIL stream_ready c=%0d got=%0b exp=1", c, in_ready);
            end
         end
         checks++;
         if (out_valid !== (c >= 3 && c < 103)) begin
            failures++;
            $display("FAIL stream_valid c=%0d got=%0b exp=%0b", c, out_valid, c >= 3 && c < 103);
         end
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 2000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         out_ready = 1'($urandom_range(0, 1));
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int t = 0; t < 60 && exp_q.size() != 0; t++) step();
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || usedw !== '0) begin
         failures++;
         $display("FAIL random_drain left=%0d usedw=%0d exp=0", exp_q.size(), usedw);
      end
      step();
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = 32'h7700_0000 + i;
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || usedw !== '0) begin
         failures++;
         $display("FAIL mid_reset vld=%0b usedw=%0d exp=0/0", out_valid, usedw);
      end
      step();
      in_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== (c == 3)) begin
            failures++;
            $display("FAIL mid_reset_valid c=%0d got=%0b exp=%0b", c, out_valid, c == 3);
         end
         step();
      end
   endtask

   task automatic test_lat3();
      int acc = 0;
      b_out_ready = 1'b1;
      for (int c = 0; c < 41; c++) begin
         b_in_valid = (c < 30); b_in_data = 32'hB000_0000 + c;
         @(negedge clk);
         checks++;
         if (b_out_valid !== (c >= 5 && c < 35)) begin
            failures++;
            $display("FAIL l3_stream_valid c=%0d got=%0b exp=%0b", c, b_out_valid, c >= 5 && c < 35);
         end
         step();
      end
      b_out_ready = 1'b0;
      for (int i = 0; i < 25; i++) begin
         b_in_valid = 1'b1; b_in_data = 32'hC000_0000 + i;
         @(negedge clk);
         if (b_in_ready) acc++;
         step();
      end
      b_in_valid = 1'b0;
      repeat (4) step();
      @(negedge clk);
      checks++;
      if (acc != 21 || b_usedw !== 6'd21 || b_in_ready !== 1'b0) begin
         failures++;
         $display("FAIL l3_capacity acc=%0d usedw=%0d rdy=%0b exp=21/21/0", acc, b_usedw, b_in_ready);
      end
      step();
      b_out_ready = 1'b1;
      for (int t = 0; t < 50 && exp_b.size() != 0; t++) step();
      @(negedge clk);
      checks++;
      if (exp_b.size() != 0 || b_usedw !== '0 || b_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL l3_drain left=%0d usedw=%0d exp=0", exp_b.size(), b_usedw);
      end
      step();
   endtask

   initial begin
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      test_reset();
      test_single_word();
      test_fill();
      test_streaming();
      test_random();
      test_mid_reset();
      test_lat3();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
